// File: rtl/axi2s_pkg.sv
// Shared constants and types for the multi-channel AXI2S register file.
// Register map offsets, reset values and the timing register bundle.
package axi2s_pkg;

    localparam int unsigned AW  = 18;
    localparam int unsigned DW  = 32;
    localparam int unsigned TW  = 24;
    localparam int unsigned SW  = 18;
    localparam int unsigned STW = 16;

    // Channel windows start at 0x100 with a 0x40 stride
    localparam logic [11:0]  CH_WIN_BASE   = 12'h100;
    localparam int unsigned  CH_STRIDE_LG2 = 6;

    localparam logic [7:0] G_CTRL      = 8'h00;
    localparam logic [7:0] G_STATUS    = 8'h04;
    localparam logic [7:0] G_IRQMASK   = 8'h08;
    localparam logic [7:0] G_FRAME_LEN = 8'h20;
    localparam logic [7:0] G_FRAME_ADJ = 8'h24;
    localparam logic [7:0] G_TSTART    = 8'h30;
    localparam logic [7:0] G_TEND      = 8'h34;
    localparam logic [7:0] G_RSTART    = 8'h38;
    localparam logic [7:0] G_REND      = 8'h3C;

    localparam logic [5:0] CH_CTRL  = 6'h00;
    localparam logic [5:0] CH_IBASE = 6'h04;
    localparam logic [5:0] CH_ISIZE = 6'h08;
    localparam logic [5:0] CH_OBASE = 6'h0C;
    localparam logic [5:0] CH_OSIZE = 6'h10;
    localparam logic [5:0] CH_IACNT = 6'h14;
    localparam logic [5:0] CH_IBCNT = 6'h18;
    localparam logic [5:0] CH_OACNT = 6'h1C;
    localparam logic [5:0] CH_OBCNT = 6'h20;

    localparam int unsigned CTRL_ARM_BIT = 8;
    localparam int unsigned ST_IERR_LSB  = 0;
    localparam int unsigned ST_OERR_LSB  = 8;

    localparam logic [DW-1:0] RST_BUF_BASE  = 32'hfffc0000;
    localparam logic [SW-1:0] RST_BUF_SIZE  = 18'h400;
    localparam logic [TW-1:0] RST_FRAME_LEN = 24'd1920;
    localparam logic [TW-1:0] RST_FRAME_END = 24'd1919;

    typedef struct packed {
        logic [TW-1:0] frame_len;
        logic [TW-1:0] frame_adj;
        logic [TW-1:0] tstart;
        logic [TW-1:0] tend;
        logic [TW-1:0] rstart;
        logic [TW-1:0] rend;
    } timing_t;

    localparam timing_t TIMING_RST = '{
        frame_len: RST_FRAME_LEN,
        frame_adj: '0,
        tstart:    '0,
        tend:      RST_FRAME_END,
        rstart:    '0,
        rend:      RST_FRAME_END
    };

endpackage

// File: rtl/axi2s_chreg_if.sv
// CPU register bus seen by axi2s_chreg: access strobe, write data and
// registered read return.
interface axi2s_chreg_if;
    import axi2s_pkg::*;

    logic          en;
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          rvalid;

    modport master (output en, wen, addr, din, input dout, rvalid);
    modport slave  (input en, wen, addr, din, output dout, rvalid);
endinterface

// File: rtl/axi2s_ch_regs.sv
// One DMA channel pair: writable enable/base/size registers plus a
// combinational read mux over its 0x40-byte window.
module axi2s_ch_regs
    import axi2s_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic [5:0]    off,
    input  logic [DW-1:0] din,
    input  logic [SW-1:0] iacnt,
    input  logic [SW-1:0] oacnt,
    input  logic [DW-1:0] ibcnt,
    input  logic [DW-1:0] obcnt,
    output logic          ien,
    output logic          oen,
    output logic [DW-1:0] ibase,
    output logic [DW-1:0] obase,
    output logic [SW-1:0] isize,
    output logic [SW-1:0] osize,
    output logic [DW-1:0] rdata_c
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ien   <= 1'b0;
            oen   <= 1'b0;
            ibase <= RST_BUF_BASE;
            obase <= RST_BUF_BASE;
            isize <= RST_BUF_SIZE;
            osize <= RST_BUF_SIZE;
        end else if (wr) begin
            case (off)
                CH_CTRL:  {oen, ien} <= din[1:0];
                CH_IBASE: ibase <= din;
                CH_ISIZE: isize <= din[23:6];
                CH_OBASE: obase <= din;
                CH_OSIZE: osize <= din[23:6];
                default:  ;
            endcase
        end
    end

    // Sizes and address counters are in 64-byte units, shown at [23:6]
    always_comb begin
        rdata_c = '0;
        case (off)
            CH_CTRL:  rdata_c = DW'({oen, ien});
            CH_IBASE: rdata_c = ibase;
            CH_ISIZE: rdata_c = DW'({isize, 6'b0});
            CH_OBASE: rdata_c = obase;
            CH_OSIZE: rdata_c = DW'({osize, 6'b0});
            CH_IACNT: rdata_c = DW'({iacnt, 6'b0});
            CH_IBCNT: rdata_c = ibcnt;
            CH_OACNT: rdata_c = DW'({oacnt, 6'b0});
            CH_OBCNT: rdata_c = obcnt;
            default:  rdata_c = '0;
        endcase
    end

endmodule

// File: rtl/axi2s_chreg.sv
// Multi-channel AXI2S control/status register file: global timing, W1C
// status with maskable irq, NCH channel blocks. Define AXI2S_SHADOW_EN to
// double-buffer timing writes and commit them on an armed frame_sync.
module axi2s_chreg
    import axi2s_pkg::*;
#(
    parameter int unsigned   NCH  = 2,
    parameter logic [AW-1:0] BASE = 18'h00000
) (
    input  logic              clk,
    input  logic              rst,
    axi2s_chreg_if.slave      bus,
    output logic [NCH-1:0]    ien,
    output logic [NCH-1:0]    oen,
    output logic              tddmode,
    output logic [NCH*DW-1:0] ibase,
    output logic [NCH*DW-1:0] obase,
    output logic [NCH*SW-1:0] isize,
    output logic [NCH*SW-1:0] osize,
    input  logic [NCH*SW-1:0] iacnt,
    input  logic [NCH*SW-1:0] oacnt,
    input  logic [NCH*DW-1:0] ibcnt,
    input  logic [NCH*DW-1:0] obcnt,
    input  logic [NCH-1:0]    ierr,
    input  logic [NCH-1:0]    oerr,
    output logic [TW-1:0]     frame_len,
    output logic [TW-1:0]     frame_adj,
    output logic [TW-1:0]     tstart,
    output logic [TW-1:0]     tend,
    output logic [TW-1:0]     rstart,
    output logic [TW-1:0]     rend,
    output logic              adj_req,
    input  logic              adj_pending,
    input  logic              frame_sync,
    output logic              irq
);

    logic           hit_c, wr_c, rd_c, glob_c, gwr_c, arm_wr_c;
    logic [11:0]    pofs_c, ch_rel_c;
    logic [5:0]     ch_idx_c;
    logic [7:0]     goff_c;
    logic [NCH-1:0] ch_sel_c;
    logic [DW-1:0]  ch_rdata [NCH];
    logic [DW-1:0]  rdata_c, dout_q;
    logic           rvalid_q;
    logic [STW-1:0] status, irqmask, set_c, clr_c;
    timing_t        act, tim_src_c, tim_n_c;
    logic           armed;

    assign hit_c    = bus.en && (bus.addr[17:12] == BASE[17:12]);
    assign wr_c     = hit_c && bus.wen;
    assign rd_c     = hit_c && !bus.wen;
    assign pofs_c   = bus.addr[11:0];
    assign glob_c   = pofs_c < CH_WIN_BASE;
    assign goff_c   = pofs_c[7:0];
    assign ch_rel_c = pofs_c - CH_WIN_BASE;
    assign ch_idx_c = 6'(ch_rel_c >> CH_STRIDE_LG2);
    assign gwr_c    = wr_c && glob_c;
    assign arm_wr_c = gwr_c && (goff_c == G_CTRL) && bus.din[CTRL_ARM_BIT];

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign ch_sel_c[c] = !glob_c && (ch_idx_c == 6'(c));

        axi2s_ch_regs u_regs (
            .clk     (clk),
            .rst     (rst),
            .wr      (wr_c && ch_sel_c[c]),
            .off     (ch_rel_c[5:0]),
            .din     (bus.din),
            .iacnt   (iacnt[SW*c +: SW]),
            .oacnt   (oacnt[SW*c +: SW]),
            .ibcnt   (ibcnt[DW*c +: DW]),
            .obcnt   (obcnt[DW*c +: DW]),
            .ien     (ien[c]),
            .oen     (oen[c]),
            .ibase   (ibase[DW*c +: DW]),
            .obase   (obase[DW*c +: DW]),
            .isize   (isize[SW*c +: SW]),
            .osize   (osize[SW*c +: SW]),
            .rdata_c (ch_rdata[c])
        );
    end

    // Event set is OR-ed after the W1C clear so a coincident event survives
    assign set_c = (STW'(oerr) << ST_OERR_LSB) | (STW'(ierr) << ST_IERR_LSB);
    assign clr_c = (gwr_c && (goff_c == G_STATUS)) ? bus.din[STW-1:0] : '0;

    always_comb begin
        tim_n_c = tim_src_c;
        if (gwr_c) begin
            case (goff_c)
                G_FRAME_LEN: tim_n_c.frame_len = bus.din[TW-1:0];
                G_FRAME_ADJ: tim_n_c.frame_adj = bus.din[TW-1:0];
                G_TSTART:    tim_n_c.tstart    = bus.din[TW-1:0];
                G_TEND:      tim_n_c.tend      = bus.din[TW-1:0];
                G_RSTART:    tim_n_c.rstart    = bus.din[TW-1:0];
                G_REND:      tim_n_c.rend      = bus.din[TW-1:0];
                default:     ;
            endcase
        end
    end

`ifdef AXI2S_SHADOW_EN
    timing_t shd;
    logic    armed_n_c, commit_c;

    assign tim_src_c = shd;
    assign commit_c  = frame_sync && armed;

    // Arm write wins over a same-cycle commit so it waits for the next frame
    always_comb begin
        armed_n_c = armed;
        if (commit_c) armed_n_c = 1'b0;
        if (arm_wr_c) armed_n_c = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shd   <= TIMING_RST;
            act   <= TIMING_RST;
            armed <= 1'b0;
        end else begin
            shd   <= tim_n_c;
            armed <= armed_n_c;
            if (commit_c) act <= shd;
            if (gwr_c && (goff_c == G_FRAME_ADJ)) act.frame_adj <= bus.din[TW-1:0];
        end
    end
`else
    logic unused_c;

    assign tim_src_c = act;
    assign armed     = 1'b0;
    assign unused_c  = frame_sync ^ arm_wr_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) act <= TIMING_RST;
        else     act <= tim_n_c;
    end
`endif

    always_comb begin
        rdata_c = '0;
        if (glob_c) begin
            case (goff_c)
                G_CTRL:      rdata_c = DW'({armed, adj_pending, tddmode});
                G_STATUS:    rdata_c = DW'(status);
                G_IRQMASK:   rdata_c = DW'(irqmask);
                G_FRAME_LEN: rdata_c = DW'(tim_src_c.frame_len);
                G_FRAME_ADJ: rdata_c = DW'(tim_src_c.frame_adj);
                G_TSTART:    rdata_c = DW'(tim_src_c.tstart);
                G_TEND:      rdata_c = DW'(tim_src_c.tend);
                G_RSTART:    rdata_c = DW'(tim_src_c.rstart);
                G_REND:      rdata_c = DW'(tim_src_c.rend);
                default:     rdata_c = '0;
            endcase
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (ch_sel_c[c]) rdata_c = ch_rdata[c];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tddmode  <= 1'b0;
            status   <= '0;
            irqmask  <= '0;
            irq      <= 1'b0;
            adj_req  <= 1'b0;
            dout_q   <= '0;
            rvalid_q <= 1'b0;
        end else begin
            status   <= (status & ~clr_c) | set_c;
            irq      <= |(status & irqmask);
            adj_req  <= gwr_c && (goff_c == G_FRAME_ADJ);
            rvalid_q <= rd_c;
            dout_q   <= rd_c ? rdata_c : '0;
            if (gwr_c && (goff_c == G_CTRL))    tddmode <= bus.din[0];
            if (gwr_c && (goff_c == G_IRQMASK)) irqmask <= bus.din[STW-1:0];
        end
    end

    assign bus.dout   = dout_q;
    assign bus.rvalid = rvalid_q;
    assign frame_len  = act.frame_len;
    assign frame_adj  = act.frame_adj;
    assign tstart     = act.tstart;
    assign tend       = act.tend;
    assign rstart     = act.rstart;
    assign rend       = act.rend;

endmodule

// File: tb/tb_axi2s_chreg.sv
// Scoreboarded random/directed bench for axi2s_chreg against an array-based
// register-map model; honours AXI2S_SHADOW_EN when defined.
module tb_axi2s_chreg;

    localparam int unsigned NCH  = 2;
    localparam logic [17:0] BASE = 18'h0a000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi2s_chreg_if bus ();

    logic [NCH-1:0]    ien, oen, ierr, oerr;
    logic              tddmode, adj_req, adj_pending, frame_sync, irq;
    logic [NCH*32-1:0] ibase, obase, ibcnt, obcnt;
    logic [NCH*18-1:0] isize, osize, iacnt, oacnt;
    logic [23:0]       frame_len, frame_adj, tstart, tend, rstart, rend;

    axi2s_chreg #(.NCH(NCH), .BASE(BASE)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .ien(ien), .oen(oen), .tddmode(tddmode),
        .ibase(ibase), .obase(obase), .isize(isize), .osize(osize),
        .iacnt(iacnt), .oacnt(oacnt), .ibcnt(ibcnt), .obcnt(obcnt),
        .ierr(ierr), .oerr(oerr),
        .frame_len(frame_len), .frame_adj(frame_adj), .tstart(tstart),
        .tend(tend), .rstart(rstart), .rend(rend),
        .adj_req(adj_req), .adj_pending(adj_pending),
        .frame_sync(frame_sync), .irq(irq)
    );

    // Reference model state; timing index 0..5 = len, adj, tstart, tend, rstart, rend
    logic        m_ien [NCH], m_oen [NCH];
    logic [31:0] m_ibase [NCH], m_obase [NCH];
    logic [17:0] m_isize [NCH], m_osize [NCH];
    logic        m_tdd, m_armed, m_irq, m_adj;
    logic [15:0] m_status, m_mask;
    logic [23:0] m_act [6], m_shd [6];
    logic [31:0] exp_q [$];
    logic [11:0] gtab [10] = '{12'h000, 12'h004, 12'h008, 12'h020, 12'h024,
                               12'h030, 12'h034, 12'h038, 12'h03c, 12'h010};
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    function automatic logic [17:0] A(input logic [11:0] off);
        return {BASE[17:12], off};
    endfunction

    function automatic int tidx(input logic [11:0] o);
        case (o)
            12'h020: return 0;
            12'h024: return 1;
            12'h030: return 2;
            12'h034: return 3;
            12'h038: return 4;
            12'h03c: return 5;
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] mread(input logic [11:0] o);
        int c, r, t;
        logic shadow = 1'b0;
`ifdef AXI2S_SHADOW_EN
        shadow = 1'b1;
`endif
        if (o < 12'h100) begin
            t = tidx(o);
            if (t >= 0) return 32'(shadow ? m_shd[t] : m_act[t]);
            if (o == 12'h000) return {29'b0, m_armed, adj_pending, m_tdd};
            if (o == 12'h004) return {16'b0, m_status};
            if (o == 12'h008) return {16'b0, m_mask};
            return 32'h0;
        end
        c = (int'(o) - 256) / 64;
        r = (int'(o) - 256) % 64;
        if (c >= NCH) return 32'h0;
        case (r)
            0:  return {30'b0, m_oen[c], m_ien[c]};
            4:  return m_ibase[c];
            8:  return {8'b0, m_isize[c], 6'b0};
            12: return m_obase[c];
            16: return {8'b0, m_osize[c], 6'b0};
            20: return {8'b0, iacnt[18*c +: 18], 6'b0};
            24: return ibcnt[32*c +: 32];
            28: return {8'b0, oacnt[18*c +: 18], 6'b0};
            32: return obcnt[32*c +: 32];
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_ien[c] = 0; m_oen[c] = 0;
            m_ibase[c] = 32'hfffc0000; m_obase[c] = 32'hfffc0000;
            m_isize[c] = 18'h400; m_osize[c] = 18'h400;
        end
        m_act = '{24'd1920, 24'd0, 24'd0, 24'd1919, 24'd0, 24'd1919};
        m_shd = m_act;
        m_tdd = 0; m_armed = 0; m_irq = 0; m_adj = 0;
        m_status = 0; m_mask = 0;
        exp_q.delete();
    endtask

    task automatic check_outputs();
        logic [NCH*32-1:0] eib, eob;
        logic [NCH*18-1:0] eis, eos;
        logic [NCH-1:0]    eie, eoe;
        for (int c = 0; c < NCH; c++) begin
            eib[32*c +: 32] = m_ibase[c]; eob[32*c +: 32] = m_obase[c];
            eis[18*c +: 18] = m_isize[c]; eos[18*c +: 18] = m_osize[c];
            eie[c] = m_ien[c]; eoe[c] = m_oen[c];
        end
        chk("ibase", ibase, eib);
        chk("obase", obase, eob);
        chk("isize", isize, eis);
        chk("osize", osize, eos);
        chk("ien_oen", {ien, oen}, {eie, eoe});
        chk("tddmode", tddmode, m_tdd);
        chk("timing", {frame_len, frame_adj, tstart, tend, rstart, rend},
            {m_act[0], m_act[1], m_act[2], m_act[3], m_act[4], m_act[5]});
        chk("irq", irq, m_irq);
        chk("adj_req", adj_req, m_adj);
    endtask

    // One bus cycle: drive, advance the model, clock, then compare outputs
    task automatic cyc(input logic e, input logic w, input logic [17:0] a,
                       input logic [31:0] d, input logic [NCH-1:0] ie,
                       input logic [NCH-1:0] oe, input logic fs);
        logic        hit;
        logic [11:0] o;
        logic [15:0] clr, set;
        int c, r, t;
        bus.en = e; bus.wen = w; bus.addr = a; bus.din = d;
        ierr = ie; oerr = oe; frame_sync = fs;
        hit = e && (a[17:12] == BASE[17:12]);
        o = a[11:0];
        if (hit && !w) exp_q.push_back(mread(o));
        clr = (hit && w && o == 12'h004) ? d[15:0] : 16'h0;
        set = 16'h0;
        for (int i = 0; i < NCH; i++) begin
            set[i] = ie[i];
            set[8 + i] = oe[i];
        end
        m_irq = |(m_status & m_mask);
        m_adj = 0;
        m_status = (m_status & ~clr) | set;
`ifdef AXI2S_SHADOW_EN
        if (fs && m_armed) begin
            m_act = m_shd;
            m_armed = 0;
        end
`endif
        if (hit && w) begin
            if (o < 12'h100) begin
                t = tidx(o);
                if (o == 12'h000) begin
                    m_tdd = d[0];
`ifdef AXI2S_SHADOW_EN
                    if (d[8]) m_armed = 1;
`endif
                end else if (o == 12'h008) begin
                    m_mask = d[15:0];
                end else if (t == 1) begin
                    m_act[1] = d[23:0]; m_shd[1] = d[23:0]; m_adj = 1;
                end else if (t >= 0) begin
`ifdef AXI2S_SHADOW_EN
                    m_shd[t] = d[23:0];
`else
                    m_act[t] = d[23:0];
`endif
                end
            end else begin
                c = (int'(o) - 256) / 64;
                r = (int'(o) - 256) % 64;
                if (c < NCH) begin
                    case (r)
                        0:  begin m_ien[c] = d[0]; m_oen[c] = d[1]; end
                        4:  m_ibase[c] = d;
                        8:  m_isize[c] = d[23:6];
                        12: m_obase[c] = d;
                        16: m_osize[c] = d[23:6];
                        default: ;
                    endcase
                end
            end
        end
        @(posedge clk);
        #1;
        bus.en = 0; bus.wen = 0; ierr = 0; oerr = 0; frame_sync = 0;
        check_outputs();
    endtask

    task automatic wr(input logic [11:0] o, input logic [31:0] d);
        cyc(1, 1, A(o), d, '0, '0, 0);
    endtask

    task automatic rd(input logic [11:0] o);
        cyc(1, 0, A(o), 32'h0, '0, '0, 0);
    endtask

    task automatic idle(input logic [NCH-1:0] ie, input logic fs);
        cyc(0, 0, 18'h0, 32'h0, ie, '0, fs);
    endtask

    // Scoreboard monitor: every rvalid pops one expected read
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rvalid) begin
                if (exp_q.size() == 0) chk("rvalid_unexpected", 1, 0);
                else                   chk("rdata", bus.dout, exp_q.pop_front());
            end else begin
                chk("dout_idle", bus.dout, 0);
            end
        end
    end

    initial begin
        logic [11:0] off;
        logic [17:0] a;
        rst = 1; bus.en = 0; bus.wen = 0; bus.addr = 0; bus.din = 0;
        ierr = 0; oerr = 0; frame_sync = 0; adj_pending = 0;
        iacnt = {NCH{18'h2a5c3}}; oacnt = {NCH{18'h1b7e1}};
        ibcnt = {$urandom, $urandom}; obcnt = {$urandom, $urandom};
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 0;
        check_outputs();
        chk("ibase_rst", ibase, {NCH{32'hfffc0000}});
        chk("frame_len_rst", frame_len, 24'd1920);
        chk("tend_rst", tend, 24'd1919);
        chk("irq_rst", irq, 1'b0);

        rd(12'h108);
        chk("isize_rd", {bus.rvalid, bus.dout}, {1'b1, 32'h00010000});

        wr(12'h144, 32'h12340000);
        chk("ch1_ibase", ibase[63:32], 32'h12340000);
        chk("ch0_ibase", ibase[31:0], 32'hfffc0000);
        rd(12'h184);
        chk("ch2_rd", {bus.rvalid, bus.dout}, {1'b1, 32'h0});
        rd(12'h15c);
        rd(12'h148);

        wr(12'h008, 32'h2);
        idle(2'b10, 0);
        chk("irq_lag", irq, 1'b0);
        idle('0, 0);
        chk("irq_set", irq, 1'b1);
        cyc(1, 1, A(12'h004), 32'h2, 2'b10, '0, 0);
        rd(12'h004);
        chk("status_set_wins", bus.dout, 32'h2);
        wr(12'h004, 32'h2);
        idle('0, 0);
        idle('0, 0);
        chk("irq_clr", irq, 1'b0);

        wr(12'h024, 32'd5);
        chk("adj_pulse", {adj_req, frame_adj}, {1'b1, 24'd5});
        wr(12'h024, 32'd6);
        chk("adj_b2b", adj_req, 1'b1);
        idle('0, 0);
        chk("adj_end", adj_req, 1'b0);
        adj_pending = 1;
        rd(12'h000);
        chk("ctrl_adj_pending", bus.dout[1], 1'b1);
        adj_pending = 0;

        a = BASE ^ 18'h01000;
        cyc(1, 1, {a[17:12], 12'h144}, 32'hdeadbeef, '0, '0, 0);
        chk("offpage_wr", ibase[63:32], 32'h12340000);
        cyc(1, 0, {a[17:12], 12'h144}, 32'h0, '0, '0, 0);
        chk("offpage_rd", {bus.rvalid, bus.dout}, {1'b0, 32'h0});

        wr(12'h034, 32'd999);
`ifdef AXI2S_SHADOW_EN
        chk("tend_shadowed", tend, 24'd1919);
        wr(12'h000, 32'h100);
        chk("tend_armed", tend, 24'd1919);
        idle('0, 1);
        chk("tend_commit", tend, 24'd999);
        rd(12'h000);
        chk("armed_clr", bus.dout[2], 1'b0);
        wr(12'h034, 32'd500);
        cyc(1, 1, A(12'h000), 32'h100, '0, '0, 1);
        chk("arm_same_cycle", tend, 24'd999);
        idle('0, 1);
        chk("arm_next_sync", tend, 24'd500);
        wr(12'h030, 32'd7);
        wr(12'h000, 32'h100);
        @(posedge clk);
        #1 rst = 1;
        model_reset();
        @(posedge clk);
        #1 rst = 0;
        idle('0, 1);
        chk("reset_aborts", tstart, 24'd0);
`else
        chk("tend_direct", tend, 24'd999);
        wr(12'h000, 32'h101);
        rd(12'h000);
        chk("armed_zero", bus.dout[2:0], 3'b001);
`endif

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 1) == 1) off = gtab[$urandom_range(0, 9)];
            else off = 12'h100 + 12'($urandom_range(0, 3)) * 12'h040
                             + 12'($urandom_range(0, 9)) * 12'h004;
            a = A(off);
            if ($urandom_range(0, 7) == 0) a[17:12] = a[17:12] ^ 6'h1;
            adj_pending = 1'($urandom);
            cyc($urandom_range(0, 3) != 0, 1'($urandom), a, $urandom,
                ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0,
                ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0,
                $urandom_range(0, 7) == 0);
        end

        idle('0, 0);
        idle('0, 0);
        chk("rd_queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi2s_chreg.md
# axi2s_chreg

Multi-channel control/status register file for the AXI-to-stream DMA engine, the parametrised successor of the single-channel AXI2S register block. It serves NCH independent input/output DMA channel pairs, global frame timing with optional double-buffered commit at frame boundaries, sticky W1C error status with a maskable interrupt, and a registered read path. It sits on the CPU register bus between the bus bridge and the DMA/frame-timing logic.

## Interface
- NCH, 2: channel count, 1..8
- BASE, 18'h00000: 4 KB page base; only addr[17:12] compared
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- en, wen  in  1  bus access strobe / write qualifier
- addr  in  18  byte address
- din  in  32  write data
- dout  out  32  read data, registered
- rvalid  out  1  read data valid pulse
- ien, oen  out  NCH  per-channel input/output enables
- tddmode  out  1  TDD mode
- ibase, obase  out  NCH*32  buffer bases, channel c at [32c+31:32c]
- isize, osize  out  NCH*18  buffer sizes in 64-byte units, bits [23:6]
- iacnt, oacnt  in  NCH*18  address counters; ibcnt, obcnt  in  NCH*32  byte counters
- ierr, oerr  in  NCH  overflow/underflow event pulses
- frame_len, frame_adj, tstart, tend, rstart, rend  out  24 each  active timing values
- adj_req  out  1  one-cycle pulse on FRAME_ADJ write
- adj_pending  in  1  adjust in progress
- frame_sync  in  1  frame-boundary pulse
- irq  out  1  interrupt, level, registered

## Operation
- Hit = en & addr[17:12]==BASE[17:12]. Writes and reads outside the page are ignored; dout stays 0.
- Global offsets: 0x00 CTRL (W: bit0 tddmode, bit8 arm commit; R: bit0 tddmode, bit1 adj_pending, bit2 armed), 0x04 STATUS (bit c ierr[c], bit 8+c oerr[c]; W1C), 0x08 IRQMASK (same layout), 0x20 FRAME_LEN, 0x24 FRAME_ADJ, 0x30 TSTART, 0x34 TEND, 0x38 RSTART, 0x3C REND.
- Channel c window at 0x100 + c*0x40: +0x00 CTRL (bit0 ien, bit1 oen), +0x04 IBASE, +0x08 ISIZE (din[23:6]), +0x0C OBASE, +0x10 OSIZE, read-only +0x14 IACNT (at [23:6], rest 0), +0x18 IBCNT, +0x1C OACNT, +0x20 OBCNT. All writable registers read back.
- c ≥ NCH, or an unmapped offset: writes ignored, reads 0 with rvalid.
- Status: ierr/oerr set sticky bits; W1C clears; simultaneous set and clear of the same bit → set wins.
- irq <= |(STATUS & IRQMASK), updated every cycle.
- FRAME_ADJ write stores value and pulses adj_req the next cycle; back-to-back writes give back-to-back pulses.

## Timing
- Read: hit & ~wen in cycle N → dout/rvalid valid in N+1; rvalid high one cycle; dout returns to 0 when there is no read.
- Write: register updates on the clock edge of the write cycle; outputs change in N+1.
- irq lags the status change by one cycle.
- Reset values: ien/oen 0, tddmode 0, ibase/obase 32'hfffc0000, isize/osize 18'h400, frame_len 1920, frame_adj 0, tstart/rstart 0, tend/rend 1919, STATUS 0, IRQMASK 0, armed 0, irq 0, adj_req 0, dout 0, rvalid 0. Shadow registers take the same values as the active registers. Reset mid-operation aborts any pending commit.

## Configuration
- AXI2S_SHADOW_EN defined: timing writes (0x20, 0x30–0x3C) go to shadow registers. A CTRL write with bit8 set arms the commit. On frame_sync with armed=1, all six active values load from shadow and armed clears. frame_sync samples the pre-write armed value, so an arm write in the same cycle waits for the next frame_sync. Reads return shadow values.
- Undefined: timing writes update active registers directly; bit8 is ignored and armed reads 0.

## Structure
- Package axi2s_pkg: offset constants, channel stride 0x40, channel window base 0x100, reset constants (base, size, 1920, 1919), status bit positions.
- Sub-module axi2s_ch_regs: per-channel writable registers and read mux, instantiated NCH times by generate. The top level holds the global registers, status/irq logic and the final read mux.

## Test plan
- Reset → ibase all 32'hfffc0000, frame_len 1920, tend 1919, irq 0; read 0x100+0x08 returns 32'h00010000.
- Write 0x140+0x04 = 32'h12340000 (ch1 IBASE) → ibase[63:32] updates, ch0 unchanged; read at NCH=2 from ch2 window → 0 with rvalid.
- Pulse ierr[1], IRQMASK=0x2 → STATUS=0x2, irq high one cycle later; W1C 0x2 in the same cycle as a new ierr[1] → bit stays set.
- With the macro defined: write TEND=999, arm commit → tend stays 1919 until frame_sync, then 999, armed=0; arm and frame_sync in the same cycle → no commit.
- FRAME_ADJ write of 5 → adj_req one-cycle pulse, frame_adj=5; adj_pending=1 reads as CTRL bit1.
- Write with addr[17:12]≠BASE → no register change; read → dout 0, rvalid 0.
